uart_tx_datapath: RTL and testbench

- Bit-level datapath of the UART transmitter, directly downstream of the TX control FSM.
- Latches the parallel byte and computes its parity at load time.
- Serialises the byte LSB-first under the FSM's ser_en and returns ser_done to the FSM.
- Drives the registered serial line TX_OUT, choosing start, stop/idle, data or parity according to the FSM's mux_sel.

---
 rtl/uart_tx_datapath_if.sv | 39 +++
 rtl/uart_tx_datapath.sv | 99 +++++++++
 tb/tb_uart_tx_datapath.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_datapath_if.sv
// Bundle between the UART TX control FSM (master) and the bit-level TX datapath (slave).
// It carries the parallel load, the parity controls, the serializer controls and the serial line.
interface uart_tx_datapath_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  busy;
    logic                  PAR_TYP;
    logic                  par_calc_en;
    logic                  ser_en;
    logic [1:0]            mux_sel;
    logic                  ser_done;
    logic                  TX_OUT;

    modport master (
        output P_DATA,
        output Data_Valid,
        output busy,
        output PAR_TYP,
        output par_calc_en,
        output ser_en,
        output mux_sel,
        input  ser_done,
        input  TX_OUT
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  busy,
        input  PAR_TYP,
        input  par_calc_en,
        input  ser_en,
        input  mux_sel,
        output ser_done,
        output TX_OUT
    );
endinterface

// File: rtl/uart_tx_datapath.sv
// UART TX bit-level datapath: latches the byte and its parity at load time, shifts it out LSB-first
// under the FSM's ser_en, and drives a registered, glitch-free TX_OUT selected by mux_sel.
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_datapath_if.slave    bus
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  ser_bit_q;
    logic                  ser_bit_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_d;
    logic                  parity_q;
    logic                  parity_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  load_s;
    logic                  mux_s;

    assign load_s = bus.Data_Valid & ~bus.busy;

    // Load / shift / idle next-state; a load takes priority over a simultaneous shift.
    always_comb begin
        shift_d   = shift_q;
        ser_bit_d = ser_bit_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        if (load_s) begin
            shift_d   = bus.P_DATA;
            bit_cnt_d = {CNT_W{1'b0}};
            if (bus.par_calc_en) begin
                parity_d = calc_parity(bus.P_DATA, bus.PAR_TYP);
            end else begin
                parity_d = parity_q;
            end
        end else if (bus.ser_en) begin
            ser_bit_d = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
            // Saturate so a long ser_en burst can never wrap back onto CNT_DONE.
            if (bit_cnt_q == CNT_MAX) begin
                bit_cnt_d = bit_cnt_q;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
        end else begin
            bit_cnt_d = {CNT_W{1'b0}};
        end
    end

    // Line source selection; tx_d feeds the output flop so TX_OUT never glitches.
    always_comb begin
        mux_s = 1'b1;
        case (bus.mux_sel)
            SEL_START:  mux_s = 1'b0;
            SEL_STOP:   mux_s = 1'b1;
            SEL_DATA:   mux_s = ser_bit_q;
            SEL_PARITY: mux_s = parity_q;
            default:    mux_s = 1'b1;
        endcase
        tx_d = mux_s;
    end

    // Datapath state and output line registers; the line idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= {DATA_WIDTH{1'b0}};
            ser_bit_q <= 1'b0;
            bit_cnt_q <= {CNT_W{1'b0}};
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            shift_q   <= shift_d;
            ser_bit_q <= ser_bit_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.ser_done = (bit_cnt_q == CNT_DONE);
    assign bus.TX_OUT   = tx_q;
endmodule

// File: tb/tb_uart_tx_datapath.sv
// Bench for uart_tx_datapath: plays the TX FSM for 8-bit and 5-bit instances and compares TX_OUT and
// ser_done against frames built from a byte/parity model.
module tb_uart_tx_datapath;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p_data;
    logic       dv;
    logic       busy;
    logic       pt;
    logic       pce;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       tx8, done8, tx5, done5;

    int checks = 0;
    int errors = 0;

    // model: index 0 = 8-bit instance, index 1 = 5-bit instance
    logic [7:0] m_data [2];
    logic       m_par  [2];

    always #5 clk = ~clk;

    uart_tx_datapath_if #(.DATA_WIDTH(8)) b8 ();
    uart_tx_datapath_if #(.DATA_WIDTH(5)) b5 ();

    assign b8.P_DATA      = p_data;
    assign b8.Data_Valid  = dv;
    assign b8.busy        = busy;
    assign b8.PAR_TYP     = pt;
    assign b8.par_calc_en = pce;
    assign b8.ser_en      = ser_en;
    assign b8.mux_sel     = mux_sel;
    assign b5.P_DATA      = p_data[4:0];
    assign b5.Data_Valid  = dv;
    assign b5.busy        = busy;
    assign b5.PAR_TYP     = pt;
    assign b5.par_calc_en = pce;
    assign b5.ser_en      = ser_en;
    assign b5.mux_sel     = mux_sel;
    assign tx8   = b8.TX_OUT;
    assign done8 = b8.ser_done;
    assign tx5   = b5.TX_OUT;
    assign done5 = b5.ser_done;

    uart_tx_datapath #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    uart_tx_datapath #(.DATA_WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    function automatic logic ref_parity(input logic [7:0] d, input int w, input logic odd_type);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        if (odd_type) return ((ones % 2) == 0);
        else          return ((ones % 2) == 1);
    endfunction

    task automatic model_load(input logic [7:0] d, input logic ptv, input logic pcev);
        m_data[0] = d;
        m_data[1] = {3'b000, d[4:0]};
        if (pcev) begin
            m_par[0] = ref_parity(d, 8, ptv);
            m_par[1] = ref_parity(d, 5, ptv);
        end
    endtask

    task automatic model_reset();
        m_data[0] = 8'h00;
        m_data[1] = 8'h00;
        m_par[0]  = 1'b0;
        m_par[1]  = 1'b0;
    endtask

    task automatic drive_idle();
        mux_sel = 2'b01;
        ser_en  = 1'b0;
        dv      = 1'b0;
        busy    = 1'b0;
        p_data  = 8'($urandom);
        pt      = 1'($urandom);
        pce     = 1'($urandom);
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            #1;
            checks++;
            if (done8 !== 1'b0 || done5 !== 1'b0) begin
                errors++;
                $display("FAIL %s idle ser_done: got %b/%b expected 0/0", name, done8, done5);
            end
            @(negedge clk);
            checks++;
            if (tx8 !== 1'b1 || tx5 !== 1'b1) begin
                errors++;
                $display("FAIL %s idle TX_OUT: got %b/%b expected 1/1", name, tx8, tx5);
            end
        end
    endtask

    // Plays one frame as the FSM would and checks the line one cycle behind each state.
    task automatic run_frame(input string name, input int w, input logic [7:0] data, input logic ptv,
                             input logic pcev, input bit with_par, input bit do_load, input bit poke_ff);
        logic [1:0] c_mux  [$];
        logic       c_en   [$];
        logic       c_tx   [$];
        logic       c_done [$];
        bit         c_load [$];
        int         idx;
        logic [7:0] bits;
        logic       par;
        logic       got;
        idx = (w == 5) ? 1 : 0;
        if (do_load) begin
            model_load(data, ptv, pcev);
            c_mux.push_back(2'b01); c_en.push_back(1'b0); c_tx.push_back(1'b1);
            c_done.push_back(1'b0); c_load.push_back(1'b1);
        end
        bits = m_data[idx];
        par  = m_par[idx];
        c_mux.push_back(2'b00); c_en.push_back(1'b1); c_tx.push_back(1'b0);
        c_done.push_back(1'b0); c_load.push_back(1'b0);
        for (int k = 1; k <= w; k++) begin
            c_mux.push_back(2'b10); c_en.push_back(1'b1); c_tx.push_back(bits[k-1]);
            c_done.push_back(k == w); c_load.push_back(1'b0);
        end
        if (with_par) begin
            c_mux.push_back(2'b11); c_en.push_back(1'b0); c_tx.push_back(par);
            c_done.push_back(1'b0); c_load.push_back(1'b0);
        end
        c_mux.push_back(2'b01); c_en.push_back(1'b0); c_tx.push_back(1'b1);
        c_done.push_back(1'b0); c_load.push_back(1'b0);

        for (int i = 0; i < c_mux.size(); i++) begin
            if (c_load[i]) begin
                p_data = data; pt = ptv; pce = pcev; dv = 1'b1; busy = 1'b0;
            end else begin
                p_data = 8'($urandom); pt = 1'($urandom); pce = 1'($urandom);
                dv = 1'($urandom); busy = 1'b1;
                if (poke_ff && i == 4) begin
                    p_data = 8'hFF; dv = 1'b1;
                end
            end
            mux_sel = c_mux[i];
            ser_en  = c_en[i];
            #1;
            got = (idx == 1) ? done5 : done8;
            checks++;
            if (got !== c_done[i]) begin
                errors++;
                $display("FAIL %s ser_done cycle %0d: got %b expected %b", name, i, got, c_done[i]);
            end
            @(negedge clk);
            got = (idx == 1) ? tx5 : tx8;
            checks++;
            if (got !== c_tx[i]) begin
                errors++;
                $display("FAIL %s TX_OUT cycle %0d: got %b expected %b", name, i, got, c_tx[i]);
            end
        end
        m_data[0] = m_data[0] >> (w + 1);
        m_data[1] = m_data[1] >> (w + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx8 !== 1'b1 || tx5 !== 1'b1 || done8 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got tx %b/%b done %b/%b expected tx 1/1 done 0/0", tx8, tx5, done8, done5);
        end
        rst_n = 1'b1;
        idle(3, "after_reset");
    endtask

    task automatic test_reset_mid_frame();
        drive_idle();
        p_data = 8'h00; pt = 1'b1; pce = 1'b1; dv = 1'b1;
        @(negedge clk);
        mux_sel = 2'b00; ser_en = 1'b1; dv = 1'b0; busy = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            mux_sel = 2'b10;
            if (k < 8) @(negedge clk);
        end
        #1;
        checks++;
        if (done8 !== 1'b1 || tx8 !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: got done %b tx %b expected done 1 tx 0", done8, tx8);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (tx8 !== 1'b1 || done8 !== 1'b0 || tx5 !== 1'b1 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: got tx %b/%b done %b/%b expected tx 1/1 done 0/0", tx8, tx5, done8, done5);
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, "reset_release");
        run_frame("post_reset_empty", 8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_parity_paths();
        run_frame("even_a5", 8, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, "gap");
        run_frame("odd_01", 8, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("even_01", 8, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("nopar_01", 8, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame("par_hold_03", 8, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_load_blocked();
        idle(2, "gap");
        run_frame("blocked_3c", 8, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_55", 8, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("b2b_aa", 8, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, "b2b_tail");
    endtask

    task automatic test_width5();
        run_frame("w5_13", 5, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, "w5_tail");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 3) == 0) ? 5 : 8;
            run_frame("random", w, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                      1'($urandom), 1'b1, 1'($urandom));
            idle($urandom_range(0, 2), "random_gap");
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        p_data  = 8'h00;
        dv      = 1'b0;
        busy    = 1'b0;
        pt      = 1'b0;
        pce     = 1'b0;
        ser_en  = 1'b0;
        mux_sel = 2'b01;
        @(negedge clk);
        test_reset();
        test_reset_mid_frame();
        test_parity_paths();
        test_load_blocked();
        test_back_to_back();
        test_width5();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
